// File: rtl/rcv_shift_decode_if.sv
// Bundle between the receive timing logic and the serial-to-parallel decoder.
// shift_strobe marks a valid d_line sample for one cycle; byte_ready pulses once per completed rcv_data.
interface rcv_shift_decode_if;
  logic       clear;
  logic       shift_strobe;
  logic       d_line;
  logic [7:0] rcv_data;
  logic       byte_ready;
  logic       stuff_err;
  logic [2:0] bit_cnt;

  modport master (
    output clear, shift_strobe, d_line,
    input  rcv_data, byte_ready, stuff_err, bit_cnt
  );

  modport slave (
    input  clear, shift_strobe, d_line,
    output rcv_data, byte_ready, stuff_err, bit_cnt
  );
endinterface

// File: rtl/rcv_shift_decode.sv
// USB receive path: NRZI decode, bit-unstuffing and LSB-first byte assembly.
// One strobed line sample is consumed per shift_strobe; clear re-arms for a new packet.
module rcv_shift_decode #(
  parameter int STUFF_LEN = 6
) (
  input  logic                clk,
  input  logic                n_rst,
  rcv_shift_decode_if.slave   bus
);
  localparam int OW = $clog2(STUFF_LEN + 1);

  logic          prev_q, prev_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          dbit;

  assign dbit = (bus.d_line == prev_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q  <= 1'b1;
      ones_q  <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      ones_q  <= ones_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    prev_d  = prev_q;
    ones_d  = ones_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = err_q;
    if (bus.clear) begin
      // A strobe coinciding with clear is intentionally dropped; rcv_data is kept.
      prev_d  = 1'b1;
      ones_d  = '0;
      bit_d   = '0;
      shreg_d = '0;
      err_d   = 1'b0;
    end else if (bus.shift_strobe) begin
      prev_d = bus.d_line;
      if (ones_q == OW'(STUFF_LEN)) begin
        // Stuff position: discarded, and only a decoded 0 is legal here.
        ones_d = '0;
        if (dbit) err_d = 1'b1;
      end else begin
        shreg_d = {dbit, shreg_q[7:1]};
        ones_d  = dbit ? ones_q + OW'(1) : '0;
        if (bit_q == 3'd7) begin
          data_d  = {dbit, shreg_q[7:1]};
          ready_d = 1'b1;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
    end
  end

  assign bus.rcv_data   = data_q;
  assign bus.byte_ready = ready_q;
  assign bus.stuff_err  = err_q;
  assign bus.bit_cnt    = bit_q;
endmodule
